// File: rtl/link_tx_scheduler_pkg.sv
// link_sched_pkg: confirmation codes, status encoding, FSM states and frame size for the TX scheduler
package link_sched_pkg;
  localparam int PREAMBLE_BYTES = 7;
  localparam int DATA_BYTES = 64;
  localparam int CRC_BYTES = 4;
  localparam int DEF_FRAME_BITS = (PREAMBLE_BYTES + DATA_BYTES + CRC_BYTES) * 8;
  localparam logic [7:0] OKAY = 8'h05;
  localparam logic [7:0] ERROR = 8'h04;
  localparam logic [7:0] FATAL_ERROR = 8'h08;
  typedef enum logic [1:0] {
    ST_OK = 2'b00,
    ST_ERR_EXHAUSTED = 2'b01,
    ST_FATAL = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_CONF, GUARD, REPORT} state_t;
endpackage

// File: rtl/link_tx_scheduler_if.sv
// link_tx_scheduler_if: frame launch and PC confirmation signals of the RS-232 framing interface
interface link_tx_scheduler_if #(parameter int FRAME_BITS = 600) ();
  logic [FRAME_BITS-1:0] fin;
  logic fin_valid;
  logic rx_busy;
  logic [7:0] conf;
  logic conf_valid;
  modport master (output fin, fin_valid, input rx_busy, conf, conf_valid);
  modport slave (input fin, fin_valid, output rx_busy, conf, conf_valid);
endinterface

// File: rtl/link_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner search from a pointer that advances past the served requester
module rr_arbiter #(parameter int NUM_REQ = 2) (
  input logic clk,
  input logic rst_n,
  input logic [NUM_REQ-1:0] req,
  input logic adv,
  input logic [$clog2(NUM_REQ)-1:0] adv_idx,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic any
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr, off;
  logic [NUM_REQ-1:0] rot;
  logic [IW:0] sum;
  assign any = |req;
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = IW'(sum >= (IW + 1)'(NUM_REQ) ? sum - (IW + 1)'(NUM_REQ) : sum);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (adv) ptr <= (adv_idx == IW'(NUM_REQ - 1)) ? '0 : adv_idx + 1'b1;
endmodule

// File: rtl/link_tx_scheduler.sv
// link_tx_scheduler: round-robin frame launcher with confirm/retry/timeout; LINK_SCHED_STATS_EN adds stat counters
module link_tx_scheduler import link_sched_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int GUARD_CYC = 4
) (
  input logic clk,
  input logic rst_n,
  input logic [NUM_REQ-1:0] req,
  input logic [NUM_REQ*FRAME_BITS-1:0] req_frame,
  output logic [NUM_REQ-1:0] done,
  output status_t status,
  output logic busy,
  output logic fatal_lock,
  link_tx_scheduler_if.master link
`ifdef LINK_SCHED_STATS_EN
  ,
  output logic [15:0] stat_retries,
  output logic [15:0] stat_timeouts,
  output logic [15:0] stat_ok
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int GW = $clog2(GUARD_CYC + 1);
  state_t state, nxt;
  status_t rep_st;
  logic [IW-1:0] win, idx;
  logic any, conf_prev, conf_edge, grab, launch, rep, retry_inc, relaunch;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic [GW-1:0] gcnt;
  logic [FRAME_BITS-1:0] sel_frame;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .adv(state == REPORT),
    .adv_idx(idx),
    .idx(win),
    .any(any)
  );
  // only a rising edge of conf_valid counts, so a long-held strobe confirms once
  assign conf_edge = link.conf_valid & ~conf_prev;
  assign busy = state != IDLE;
  always_comb begin
    sel_frame = '0;
    for (int k = 0; k < NUM_REQ; k++) if (win == IW'(k)) sel_frame = req_frame[k*FRAME_BITS +: FRAME_BITS];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    grab = 1'b0;
    launch = 1'b0;
    rep = 1'b0;
    rep_st = ST_OK;
    retry_inc = 1'b0;
    case (state)
      IDLE: if (any && !fatal_lock) begin
        grab = 1'b1;
        nxt = LAUNCH;
      end
      LAUNCH: if (!link.rx_busy) begin
        launch = 1'b1;
        nxt = WAIT_CONF;
      end
      WAIT_CONF: if (conf_edge) begin
        if (link.conf == OKAY) begin
          rep = 1'b1;
          nxt = REPORT;
        end else if (link.conf == FATAL_ERROR) begin
          rep = 1'b1;
          rep_st = ST_FATAL;
          nxt = REPORT;
        end else if (retry < RW'(MAX_RETRY)) begin
          retry_inc = 1'b1;
          nxt = GUARD;
        end else begin
          rep = 1'b1;
          rep_st = ST_ERR_EXHAUSTED;
          nxt = REPORT;
        end
      end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
        rep = 1'b1;
        rep_st = ST_TIMEOUT;
        nxt = REPORT;
      end
      GUARD: if (gcnt == GW'(GUARD_CYC - 1)) nxt = relaunch ? LAUNCH : IDLE;
      REPORT: nxt = GUARD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      conf_prev <= 1'b0;
      done <= '0;
      status <= ST_OK;
      fatal_lock <= 1'b0;
      link.fin <= '0;
      link.fin_valid <= 1'b0;
      retry <= '0;
      timer <= '0;
      gcnt <= '0;
      relaunch <= 1'b0;
    end else begin
      conf_prev <= link.conf_valid;
      link.fin_valid <= launch;
      done <= rep ? NUM_REQ'(1) << idx : '0;
      if (rep) status <= rep_st;
      if (rep && rep_st == ST_FATAL) fatal_lock <= 1'b1;
      if (grab) begin
        idx <= win;
        link.fin <= sel_frame;
      end
      retry <= grab ? '0 : retry_inc ? retry + 1'b1 : retry;
      timer <= launch ? '0 : state == WAIT_CONF ? timer + 1'b1 : timer;
      gcnt <= state == GUARD ? gcnt + 1'b1 : '0;
      relaunch <= retry_inc ? 1'b1 : rep ? 1'b0 : relaunch;
    end
`ifdef LINK_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_retries <= '0;
      stat_timeouts <= '0;
      stat_ok <= '0;
    end else begin
      if (retry_inc && stat_retries != '1) stat_retries <= stat_retries + 1'b1;
      if (rep && rep_st == ST_TIMEOUT && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 1'b1;
      if (rep && rep_st == ST_OK && stat_ok != '1) stat_ok <= stat_ok + 1'b1;
    end
`endif
endmodule

// File: tb/tb_link_tx_scheduler.sv
// tb_link_tx_scheduler: randomized rounds against a transaction-level model, scoreboarded launches and completions
`timescale 1ns/1ps
module tb_link_tx_scheduler;
  import link_sched_pkg::*;
  localparam int N = 3, FB = 64, MR = 3, TO = 100, GC = 4;
  typedef struct {bit none; logic [7:0] code; int dly; int len;} reply_t;
  typedef struct {int idx; int st;} exp_done_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [FB-1:0] frames [N];
  logic [N*FB-1:0] req_frame;
  logic [N-1:0] done;
  status_t status;
  logic busy, fatal_lock;
  int cyc = 0, n_cmp = 0, n_fail = 0, ptr_m = 0, last_launch = -1000;
  reply_t reply_q[$];
  logic [FB-1:0] exp_fin_q[$];
  exp_done_t exp_done_q[$];
  int launch_log[$];
  link_tx_scheduler_if #(.FRAME_BITS(FB)) link ();
  for (genvar g = 0; g < N; g++) assign req_frame[g*FB +: FB] = frames[g];
  link_tx_scheduler #(.NUM_REQ(N), .FRAME_BITS(FB), .MAX_RETRY(MR), .TIMEOUT_CYC(TO), .GUARD_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_frame(req_frame), .done(done), .status(status),
    .busy(busy), .fatal_lock(fatal_lock), .link(link)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // launch monitor and completion monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && link.fin_valid) begin
      n_cmp++;
      if (cyc - last_launch < GC + 1) begin
        n_fail++;
        $display("FAIL launch_spacing: got %0d cycles need at least %0d", cyc - last_launch, GC + 1);
      end
      last_launch = cyc;
      launch_log.push_back(cyc);
      if (exp_fin_q.size() == 0) chk("launch_expected", 0, 1);
      else chk("launch_frame", link.fin, exp_fin_q.pop_front());
    end
    if (rst_n && done != '0) begin
      int di;
      exp_done_t e;
      di = -1;
      for (int k = 0; k < N; k++) if (done[k]) di = k;
      chk("done_onehot", 64'($onehot(done)), 1);
      chk("busy_at_done", busy, 1);
      if (exp_done_q.size() == 0) chk("done_expected", 0, 1);
      else begin
        e = exp_done_q.pop_front();
        chk("done_idx", di, e.idx);
        chk("status", status, e.st);
        if (e.st == 3) chk("timeout_latency", cyc - last_launch, TO);
        if (e.st == 2) chk("fatal_lock_set", fatal_lock, 1);
      end
      req = req & ~done;
    end
  end
  // PC side: answers each launch according to the scripted reply
  initial begin
    reply_t r;
    forever begin
      @(negedge clk);
      if (rst_n && link.fin_valid && reply_q.size() > 0) begin
        r = reply_q.pop_front();
        if (!r.none) begin
          repeat (r.dly) @(negedge clk);
          link.conf = r.code;
          link.conf_valid = 1'b1;
          repeat (r.len) @(negedge clk);
          link.conf_valid = 1'b0;
          link.conf = 8'($urandom);
        end
      end
    end
  end
  function automatic reply_t mk(bit none, logic [7:0] code);
    reply_t r;
    r.none = none;
    r.code = code;
    r.dly = $urandom_range(0, 20);
    r.len = $urandom_range(1, 3);
    return r;
  endfunction
  function automatic logic [7:0] err_code();
    logic [7:0] c;
    c = 8'($urandom);
    if (c == OKAY || c == FATAL_ERROR || $urandom_range(0, 1) == 1) c = ERROR;
    return c;
  endfunction
  // reference model: serve the held set in round-robin order, one scripted outcome per requester
  task automatic plan(int mask, int f_term, int f_nerr, bit allow_fatal, output bit fatal);
    int rem, i, nerr, term;
    exp_done_t e;
    rem = mask;
    fatal = 1'b0;
    for (int k = 0; k < N; k++) if ((mask >> k) & 1) frames[k] = {$urandom, $urandom};
    while (rem != 0 && !fatal) begin
      i = ptr_m;
      while (((rem >> i) & 1) == 0) i = (i + 1) % N;
      nerr = f_term == 1 ? MR + 1 : f_nerr >= 0 ? f_nerr : $urandom_range(0, MR + 1);
      if (nerr == MR + 1) term = 1;
      else if (f_term >= 0) term = f_term;
      else begin
        term = $urandom_range(0, 9);
        term = term < 6 ? 0 : term < 8 ? 3 : allow_fatal ? 2 : 0;
      end
      for (int k = 0; k < nerr; k++) begin
        exp_fin_q.push_back(frames[i]);
        reply_q.push_back(mk(1'b0, err_code()));
      end
      if (term != 1) begin
        exp_fin_q.push_back(frames[i]);
        reply_q.push_back(mk(term == 3, term == 2 ? FATAL_ERROR : OKAY));
      end
      e.idx = i;
      e.st = term;
      exp_done_q.push_back(e);
      ptr_m = (i + 1) % N;
      rem = rem & ~(1 << i);
      fatal = term == 2;
    end
    req = req | N'(mask);
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_done_q.size() != 0 || busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("round_completes_in_budget", t < 4000, 1);
    chk("leftover_launches", exp_fin_q.size(), 0);
  endtask
  task automatic check_reset_vals();
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fatal_lock", fatal_lock, 0);
    chk("rst_fin", link.fin, 0);
    chk("rst_fin_valid", link.fin_valid, 0);
  endtask
  task automatic after_fatal();
    int n0;
    n0 = launch_log.size();
    repeat (20) @(negedge clk);
    chk("locked_launch_count", launch_log.size(), n0);
    chk("locked_busy", busy, 0);
    chk("locked_fatal_lock", fatal_lock, 1);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    ptr_m = 0;
    last_launch = -1000;
    @(negedge clk);
  endtask
  initial begin
    bit fat;
    int n0, t0;
    link.rx_busy = 1'b0;
    link.conf = 8'h00;
    link.conf_valid = 1'b0;
    for (int k = 0; k < N; k++) frames[k] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    n0 = launch_log.size();
    t0 = cyc;
    plan(1, 0, 0, 1'b0, fat);
    wait_idle();
    chk("req_to_launch_latency", launch_log[n0] - t0, 2);
    plan(3, 0, 0, 1'b0, fat);
    wait_idle();
    plan(3, 0, 0, 1'b0, fat);
    wait_idle();
    n0 = launch_log.size();
    plan(2, 1, -1, 1'b0, fat);
    wait_idle();
    chk("exhaust_launches", launch_log.size() - n0, MR + 1);
    plan(1, 3, 0, 1'b0, fat);
    wait_idle();
    link.rx_busy = 1'b1;
    n0 = launch_log.size();
    plan(4, 0, 0, 1'b0, fat);
    repeat (12) @(negedge clk);
    chk("no_launch_while_rx_busy", launch_log.size(), n0);
    link.rx_busy = 1'b0;
    t0 = cyc;
    wait_idle();
    chk("launch_after_rx_busy", launch_log[n0] - t0, 1);
    for (int r = 0; r < 30; r++) begin
      plan($urandom_range(1, (1 << N) - 1), -1, -1, 1'b1, fat);
      wait_idle();
      if (fat) after_fatal();
    end
    plan((1 << N) - 1, 2, 0, 1'b1, fat);
    wait_idle();
    after_fatal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
